ram_calc_arbiter: RTL and testbench
===================================

RAM_CALC_ARBITER -- requirements
Module: ram_calc_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one RAM address calculation unit.
REQ-002 SHALL have parameter ID_W, default 2, requester ID width, equal to clog2(NUM_REQ).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_isSprite  in  NUM_REQ  1 = sprite, 0 = text.
- req_frameNumber  in  NUM_REQ*8  packed, unsigned.
- req_height  in  NUM_REQ*16  packed, unsigned.
- req_width  in  NUM_REQ*16  packed, unsigned.
- req_layerX  in  NUM_REQ*16  packed, unsigned.
- req_layerY  in  NUM_REQ*16  packed, unsigned.
- calc_newCalculation  out  1  start pulse to calc unit.
- calc_isSprite / calc_frameNumber / calc_height / calc_width / calc_layerX / calc_layerY  out  1/8/16/16/16/16  operands to calc unit.
- calc_rdy  in  1  calc unit ready (1 = idle/result valid).
- calc_addressOffsetBytes  in  27  calc unit result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  requester index of result.
- resp_addressOffsetBytes  out  27  result, bytes.
- resp_err  out  1  result aborted by timeout.
- err_timeout  out  1  sticky timeout flag.
Slice i of each packed bus is bits [i*W +: W].

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, SETTLE, WAIT, RESP.
REQ-006 IDLE: when any req_valid=1 and calc_rdy=1, SHALL grant the first requesting index at or after rr_ptr (wrapping modulo NUM_REQ), pulse req_ready[grant] for exactly that cycle, latch that requester's operands and ID, then go to ISSUE.
REQ-007 IDLE with calc_rdy=0 SHALL grant nothing and assert no req_ready.
REQ-008 ISSUE: SHALL assert calc_newCalculation=1 for exactly one cycle, then go to SETTLE.
REQ-009 SETTLE: SHALL ignore calc_rdy for one cycle, then go to WAIT.
REQ-010 WAIT: on calc_rdy=1, SHALL register calc_addressOffsetBytes into resp_addressOffsetBytes, set resp_err=0, and go to RESP.
REQ-011 WAIT SHALL count cycles from 0. If calc_rdy is still 0 when the count reaches TIMEOUT_CYCLES-1, SHALL set err_timeout=1, resp_err=1 and resp_addressOffsetBytes=0, then go to RESP.
REQ-012 RESP: SHALL hold resp_valid=1 with stable resp_id, resp_addressOffsetBytes and resp_err until resp_ready=1. On that handshake cycle it SHALL set rr_ptr=(grant+1) mod NUM_REQ and go to IDLE.
REQ-013 calc_* operand outputs SHALL hold the latched values, unchanged, from ISSUE through the end of WAIT.
REQ-014 SHALL have at most one transaction in flight. Minimum transaction length is 5 cycles (IDLE to RESP handshake, with calc_rdy high in the first WAIT cycle and resp_ready=1).
REQ-015 SHALL ignore req_valid changes and req_* operand changes outside the IDLE grant cycle.
REQ-016 A requester SHALL NOT be granted twice in a row while another requester is continuously asserting req_valid (round-robin fairness).
REQ-017 resp_valid SHALL be high only in RESP. calc_newCalculation SHALL be high only in ISSUE.
REQ-018 err_timeout SHALL remain 1 until rst.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set: state=IDLE, rr_ptr=0, timeout count=0, all req_ready=0, calc_newCalculation=0, all calc_* operand outputs=0, resp_valid=0, resp_id=0, resp_addressOffsetBytes=0, resp_err=0, err_timeout=0.
REQ-020 Reset asserted mid-transaction SHALL abandon that transaction, with no resp_valid produced for it.

Verification
REQ-021 Single request: req_valid[2]=1, sprite, frame=1, h=4, w=8, x=3, y=2, calc model 4-cycle latency, resp_ready=1 -> one req_ready[2] pulse, one calc_newCalculation pulse, resp_id=2, resp_addressOffsetBytes=0x66 (value from the calc model), resp_err=0.
REQ-022 All four requesters held valid, resp_ready=1, rr_ptr=0 -> grant order 0,1,2,3,0 and exactly one req_ready pulse per transaction.
REQ-023 Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid and outputs stable for all 10 cycles, no new grant, grant resumes after the handshake.
REQ-024 Stuck calc unit: calc_rdy held 0 after ISSUE -> after 64 WAIT cycles resp_valid=1, resp_err=1, resp_addressOffsetBytes=0, err_timeout=1 and sticky until rst.
REQ-025 rst pulsed during WAIT -> next cycle all outputs at reset values, no response emitted, and the next grant goes to the lowest valid index.
REQ-026 calc_rdy=0 while in IDLE with req_valid=0xF -> no req_ready and no calc_newCalculation until calc_rdy=1.

Source files
------------

// File: rtl/ram_calc_arbiter.sv
// Round-robin arbiter that shares one RAM address calculation unit between
// NUM_REQ requesters. Only one transaction is in flight at a time, and the
// wait for the calc unit is bounded by TIMEOUT_CYCLES.
//
// state  | meaning
// IDLE   | waiting for a request while the calc unit reports ready
// ISSUE  | one-cycle start pulse to the calc unit
// SETTLE | one cycle to let calc_rdy drop after the start pulse
// WAIT   | waiting for calc_rdy, bounded by TIMEOUT_CYCLES
// RESP   | result held until the consumer accepts it
module ram_calc_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ-1:0]     req_isSprite,
   input  logic [NUM_REQ*8-1:0]   req_frameNumber,
   input  logic [NUM_REQ*16-1:0]  req_height,
   input  logic [NUM_REQ*16-1:0]  req_width,
   input  logic [NUM_REQ*16-1:0]  req_layerX,
   input  logic [NUM_REQ*16-1:0]  req_layerY,
   output logic                   calc_newCalculation,
   output logic                   calc_isSprite,
   output logic [7:0]             calc_frameNumber,
   output logic [15:0]            calc_height,
   output logic [15:0]            calc_width,
   output logic [15:0]            calc_layerX,
   output logic [15:0]            calc_layerY,
   input  logic                   calc_rdy,
   input  logic [26:0]            calc_addressOffsetBytes,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [26:0]            resp_addressOffsetBytes,
   output logic                   resp_err,
   output logic                   err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam int              CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   state_t                 state;
   state_t                 state_nxt;
   logic [ID_W-1:0]        rr_ptr;
   logic [CNT_W-1:0]       wait_cnt;

   logic [2*NUM_REQ-1:0]   valid_dbl;
   logic [2*NUM_REQ-1:0]   valid_rot;
   logic                   grant_found;
   logic [ID_W:0]          grant_sum;
   logic [ID_W-1:0]        grant_idx;
   logic                   take_grant;
   logic                   wait_timeout;
   logic [ID_W:0]          ptr_sum;
   logic [ID_W-1:0]        ptr_nxt;

   logic                   sel_sprite;
   logic [7:0]             sel_frame;
   logic [15:0]            sel_height;
   logic [15:0]            sel_width;
   logic [15:0]            sel_layer_x;
   logic [15:0]            sel_layer_y;

   // Rotate the request vector so rr_ptr sits at bit 0, then take the lowest
   // set bit; the doubled vector makes the wrap-around free.
   always_comb begin
      valid_dbl   = {req_valid, req_valid};
      valid_rot   = valid_dbl >> rr_ptr;
      grant_found = 1'b0;
      grant_sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (valid_rot[k]) begin
            grant_found = 1'b1;
            grant_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
         end
      end
      if (grant_sum >= NUM_REQ_W) begin
         grant_sum = grant_sum - NUM_REQ_W;
      end
      grant_idx = grant_sum[ID_W-1:0];
   end

   // Operand mux for the requester being granted.
   always_comb begin
      sel_sprite  = 1'b0;
      sel_frame   = '0;
      sel_height  = '0;
      sel_width   = '0;
      sel_layer_x = '0;
      sel_layer_y = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_sprite  = req_isSprite[i];
            sel_frame   = req_frameNumber[i*8 +: 8];
            sel_height  = req_height[i*16 +: 16];
            sel_width   = req_width[i*16 +: 16];
            sel_layer_x = req_layerX[i*16 +: 16];
            sel_layer_y = req_layerY[i*16 +: 16];
         end
      end
   end

   // Next round-robin pointer is the one after the requester just served.
   always_comb begin
      ptr_sum = {1'b0, resp_id} + (ID_W+1)'(1);
      if (ptr_sum >= NUM_REQ_W) begin
         ptr_sum = '0;
      end
      ptr_nxt = ptr_sum[ID_W-1:0];
   end

   assign take_grant   = (state == S_IDLE) && calc_rdy && grant_found;
   assign wait_timeout = (state == S_WAIT) && !calc_rdy && (wait_cnt == CNT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (take_grant) state_nxt = S_ISSUE;
         S_ISSUE:  state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_WAIT;
         S_WAIT:   if (calc_rdy || wait_timeout) state_nxt = S_RESP;
         S_RESP:   if (resp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; held low during reset so nothing is accepted or started.
   always_comb begin
      req_ready           = '0;
      calc_newCalculation = 1'b0;
      resp_valid          = 1'b0;
      if (!rst) begin
         if (take_grant) begin
            req_ready = NUM_REQ'(1) << grant_idx;
         end
         calc_newCalculation = (state == S_ISSUE);
         resp_valid          = (state == S_RESP);
      end
   end

   // Operand/ID latch at grant, WAIT counter, result capture and pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr                  <= '0;
         wait_cnt                <= '0;
         calc_isSprite           <= 1'b0;
         calc_frameNumber        <= '0;
         calc_height             <= '0;
         calc_width              <= '0;
         calc_layerX             <= '0;
         calc_layerY             <= '0;
         resp_id                 <= '0;
         resp_addressOffsetBytes <= '0;
         resp_err                <= 1'b0;
         err_timeout             <= 1'b0;
      end else begin
         if (take_grant) begin
            calc_isSprite    <= sel_sprite;
            calc_frameNumber <= sel_frame;
            calc_height      <= sel_height;
            calc_width       <= sel_width;
            calc_layerX      <= sel_layer_x;
            calc_layerY      <= sel_layer_y;
            resp_id          <= grant_idx;
         end

         if (state == S_SETTLE) begin
            wait_cnt <= '0;
         end else if (state == S_WAIT && !calc_rdy) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end

         if (state == S_WAIT) begin
            if (calc_rdy) begin
               resp_addressOffsetBytes <= calc_addressOffsetBytes;
               resp_err                <= 1'b0;
            end else if (wait_timeout) begin
               resp_addressOffsetBytes <= '0;
               resp_err                <= 1'b1;
               err_timeout             <= 1'b1;
            end
         end

         if (state == S_RESP && resp_ready) begin
            rr_ptr <= ptr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_ram_calc_arbiter.sv
// Randomized bench for ram_calc_arbiter with a behavioural calc unit and a
// round-robin / address reference model.
module tb_ram_calc_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;
   localparam int TO = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_isSprite;
   logic [N*8-1:0]    req_frameNumber;
   logic [N*16-1:0]   req_height;
   logic [N*16-1:0]   req_width;
   logic [N*16-1:0]   req_layerX;
   logic [N*16-1:0]   req_layerY;
   logic              calc_newCalculation;
   logic              calc_isSprite;
   logic [7:0]        calc_frameNumber;
   logic [15:0]       calc_height;
   logic [15:0]       calc_width;
   logic [15:0]       calc_layerX;
   logic [15:0]       calc_layerY;
   logic              calc_rdy;
   logic [26:0]       calc_res = '0;
   logic              resp_valid;
   logic              resp_ready;
   logic [IW-1:0]     resp_id;
   logic [26:0]       resp_addressOffsetBytes;
   logic              resp_err;
   logic              err_timeout;

   always #5 clk = ~clk;

   ram_calc_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(TO)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_isSprite            (req_isSprite),
      .req_frameNumber         (req_frameNumber),
      .req_height              (req_height),
      .req_width               (req_width),
      .req_layerX              (req_layerX),
      .req_layerY              (req_layerY),
      .calc_newCalculation     (calc_newCalculation),
      .calc_isSprite           (calc_isSprite),
      .calc_frameNumber        (calc_frameNumber),
      .calc_height             (calc_height),
      .calc_width              (calc_width),
      .calc_layerX             (calc_layerX),
      .calc_layerY             (calc_layerY),
      .calc_rdy                (calc_rdy),
      .calc_addressOffsetBytes (calc_res),
      .resp_valid              (resp_valid),
      .resp_ready              (resp_ready),
      .resp_id                 (resp_id),
      .resp_addressOffsetBytes (resp_addressOffsetBytes),
      .resp_err                (resp_err),
      .err_timeout             (err_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Address rule of the calc unit: 16-bit pixels, sprites offset by frame.
   function automatic logic [26:0] addr_of(input logic spr, input logic [7:0] f,
                                           input logic [15:0] h, input logic [15:0] w,
                                           input logic [15:0] x, input logic [15:0] y);
      longint unsigned lf, lh, lw, lx, ly, a;
      lf = f; lh = h; lw = w; lx = x; ly = y;
      a = ly * lw + lx;
      if (spr) a = a + lf * lh * lw;
      return 27'(a * 2);
   endfunction

   // Calc unit model: drops ready for 'lat' cycles after a start pulse and
   // computes from the operands the arbiter is presenting at completion.
   int   lat = 0;
   int   busy = 0;
   logic calc_rdy_m = 1'b1;
   logic block_rdy = 1'b0;
   assign calc_rdy = calc_rdy_m & ~block_rdy;

   always @(negedge clk) begin
      if (rst) begin
         busy = 0;
         calc_rdy_m = 1'b1;
      end else if (calc_newCalculation) begin
         if (lat == 0) begin
            calc_res = addr_of(calc_isSprite, calc_frameNumber, calc_height,
                               calc_width, calc_layerX, calc_layerY);
         end else begin
            busy = lat;
            calc_rdy_m = 1'b0;
         end
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) begin
            calc_rdy_m = 1'b1;
            calc_res = addr_of(calc_isSprite, calc_frameNumber, calc_height,
                               calc_width, calc_layerX, calc_layerY);
         end
      end
   end

   logic        op_spr [N];
   logic [7:0]  op_frm [N];
   logic [15:0] op_h [N];
   logic [15:0] op_w [N];
   logic [15:0] op_x [N];
   logic [15:0] op_y [N];

   int rr_ref = 0;
   bit exp_sticky = 1'b0;

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         op_spr[i] = 1'($urandom);
         op_frm[i] = 8'($urandom);
         op_h[i]   = 16'($urandom);
         op_w[i]   = 16'($urandom);
         op_x[i]   = 16'($urandom);
         op_y[i]   = 16'($urandom);
      end
   endtask

   task automatic drive_ops();
      for (int i = 0; i < N; i++) begin
         req_isSprite[i]          = op_spr[i];
         req_frameNumber[i*8 +: 8] = op_frm[i];
         req_height[i*16 +: 16]   = op_h[i];
         req_width[i*16 +: 16]    = op_w[i];
         req_layerX[i*16 +: 16]   = op_x[i];
         req_layerY[i*16 +: 16]   = op_y[i];
      end
   endtask

   function automatic int ref_grant(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[2'((ptr + k) % N)]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // One full transaction: grant, calc, optional backpressure, handshake.
   task automatic run_txn(input logic [N-1:0] v, input int l, input int bp,
                          input bit stuck, input bit rnd, output int got_id,
                          output logic [26:0] got_addr);
      int          exp_id, exp_cyc, cyc, n_nc, n_rr;
      logic [26:0] exp_addr;
      logic        exp_err;
      if (rnd) rand_ops();
      exp_id   = ref_grant(v, rr_ref);
      exp_addr = stuck ? 27'd0 : addr_of(op_spr[exp_id], op_frm[exp_id], op_h[exp_id],
                                          op_w[exp_id], op_x[exp_id], op_y[exp_id]);
      exp_err  = stuck;
      exp_cyc  = stuck ? TO + 3 : ((l + 2 > 4) ? l + 2 : 4);
      if (stuck) exp_sticky = 1'b1;
      lat = l;

      @(negedge clk);
      block_rdy  = 1'b0;
      req_valid  = v;
      resp_ready = (bp == 0);
      drive_ops();
      #1;
      chk_val("grant", 32'(req_ready), 32'(1) << exp_id);
      got_id = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) got_id = k;

      cyc = 0; n_nc = 0; n_rr = 0;
      while (!resp_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) block_rdy = stuck;
         req_valid = 4'($urandom);
         rand_ops();
         drive_ops();
         #1;
         n_nc += int'(calc_newCalculation);
         n_rr += int'(req_ready != '0);
      end
      chk_val("resp_cycle", cyc, exp_cyc);
      chk_val("newcalc_pulses", n_nc, 1);
      chk_val("extra_ready", n_rr, 0);
      chk_val("resp_id", 32'(resp_id), exp_id);
      chk_val("resp_addr", 32'(resp_addressOffsetBytes), 32'(exp_addr));
      chk_val("resp_err", 32'(resp_err), 32'(exp_err));
      chk_val("err_timeout", 32'(err_timeout), 32'(exp_sticky));
      got_addr = resp_addressOffsetBytes;

      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         req_valid = 4'($urandom_range(1, 15));
         #1;
         chk_val("bp_valid", 32'(resp_valid), 1);
         chk_val("bp_id", 32'(resp_id), exp_id);
         chk_val("bp_addr", 32'(resp_addressOffsetBytes), 32'(exp_addr));
         chk_val("bp_err", 32'(resp_err), 32'(exp_err));
         chk_val("bp_no_grant", 32'(req_ready), 0);
      end
      if (bp > 0) begin
         @(negedge clk);
         resp_ready = 1'b1;
         #1;
         chk_val("hs_valid", 32'(resp_valid), 1);
      end
      rr_ref = (exp_id + 1) % N;

      @(negedge clk);
      req_valid = '0;
      block_rdy = 1'b0;
      #1;
      chk_val("idle_no_resp", 32'(resp_valid), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_val({tag, "_resp_valid"}, 32'(resp_valid), 0);
      chk_val({tag, "_resp_id"}, 32'(resp_id), 0);
      chk_val({tag, "_resp_addr"}, 32'(resp_addressOffsetBytes), 0);
      chk_val({tag, "_resp_err"}, 32'(resp_err), 0);
      chk_val({tag, "_err_timeout"}, 32'(err_timeout), 0);
      chk_val({tag, "_newcalc"}, 32'(calc_newCalculation), 0);
      chk_val({tag, "_ops"}, 32'(|{calc_isSprite, calc_frameNumber, calc_height,
                                   calc_width, calc_layerX, calc_layerY}), 0);
      chk_val({tag, "_ready"}, 32'(req_ready), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      block_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rr_ref = 0;
      exp_sticky = 1'b0;
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          gid;
      logic [26:0] gaddr;
      int          order [5] = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      req_valid = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         op_spr[i] = 1'b0; op_frm[i] = '0; op_h[i] = '0;
         op_w[i] = '0; op_x[i] = '0; op_y[i] = '0;
      end
      drive_ops();
      repeat (2) @(negedge clk);
      req_valid = 4'hF;
      #1;
      chk_val("ready_in_reset", 32'(req_ready), 0);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b0;
      #1;
      chk_reset_vals("por");

      // Single sprite request from requester 2, 4-cycle calc latency.
      op_spr[2] = 1'b1; op_frm[2] = 8'd1; op_h[2] = 16'd4;
      op_w[2] = 16'd8; op_x[2] = 16'd3; op_y[2] = 16'd2;
      run_txn(4'b0100, 4, 0, 1'b0, 1'b0, gid, gaddr);
      chk_val("single_id", gid, 2);
      chk_val("single_addr", 32'(gaddr), 32'h66);

      // All four held valid from rr_ptr=0.
      do_reset();
      for (int t = 0; t < 5; t++) begin
         run_txn(4'hF, int'($urandom_range(0, 5)), 0, 1'b0, 1'b1, gid, gaddr);
         chk_val("rr_order", gid, order[t]);
      end

      // Backpressure for 10 cycles.
      run_txn(4'hF, 2, 10, 1'b0, 1'b1, gid, gaddr);

      // Calc unit busy in IDLE: nothing granted or started.
      @(negedge clk);
      block_rdy = 1'b1;
      req_valid = 4'hF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk_val("busy_no_ready", 32'(req_ready), 0);
         chk_val("busy_no_newcalc", 32'(calc_newCalculation), 0);
      end
      run_txn(4'hF, 1, 0, 1'b0, 1'b1, gid, gaddr);

      // Stuck calc unit, then sticky flag across a good transaction.
      run_txn(4'($urandom_range(1, 15)), 3, 2, 1'b1, 1'b1, gid, gaddr);
      run_txn(4'($urandom_range(1, 15)), 2, 0, 1'b0, 1'b1, gid, gaddr);
      chk_val("sticky_good_err", 32'(resp_err), 0);

      // Reset during WAIT: move rr_ptr off zero first.
      do_reset();
      run_txn(4'b0010, 0, 0, 1'b0, 1'b1, gid, gaddr);
      rand_ops();
      lat = 20;
      @(negedge clk);
      req_valid = 4'b1000;
      drive_ops();
      #1;
      chk_val("pre_rst_grant", 32'(req_ready), 32'b1000);
      repeat (4) begin
         @(negedge clk);
         req_valid = '0;
      end
      do_reset();
      chk_reset_vals("mid_rst");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk_val("mid_rst_no_resp", 32'(resp_valid), 0);
      end
      run_txn(4'b1001, 1, 0, 1'b0, 1'b1, gid, gaddr);
      chk_val("post_rst_lowest", gid, 0);

      // Randomized traffic with occasional stuck calc unit.
      for (int t = 0; t < 40; t++) begin
         run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
                 1'b1, gid, gaddr);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
